intr_ctrl: RTL and testbench

Machine-level interrupt controller that consumes the pending bits published by the mip register, qualifies them with mie and mstatus.MIE, selects the highest-priority source, and hands a single trap request to the pipeline through a registered req/ack handshake. It sits between the CSR file and the trap/commit logic in the execute/writeback stage. It tracks whether a trap is in flight so the same interrupt is not re-requested before mret.

---
 rtl/intr_pkg.sv | 58 +++++
 rtl/intr_prio_enc.sv | 22 ++
 rtl/intr_ctrl.sv | 123 ++++++++++++
 tb/tb_intr_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared constants and types for the machine-level interrupt controller.
package intr_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IRQ_W  = 12;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned N_SRC  = 9;

  // mip/mie bit positions
  localparam int unsigned BIT_USI = 0;
  localparam int unsigned BIT_SSI = 1;
  localparam int unsigned BIT_MSI = 3;
  localparam int unsigned BIT_UTI = 4;
  localparam int unsigned BIT_STI = 5;
  localparam int unsigned BIT_MTI = 7;
  localparam int unsigned BIT_UEI = 8;
  localparam int unsigned BIT_SEI = 9;
  localparam int unsigned BIT_MEI = 11;

  // Cause codes equal the mip bit index
  localparam logic [CODE_W-1:0] CAUSE_USI = CODE_W'(BIT_USI);
  localparam logic [CODE_W-1:0] CAUSE_SSI = CODE_W'(BIT_SSI);
  localparam logic [CODE_W-1:0] CAUSE_MSI = CODE_W'(BIT_MSI);
  localparam logic [CODE_W-1:0] CAUSE_UTI = CODE_W'(BIT_UTI);
  localparam logic [CODE_W-1:0] CAUSE_STI = CODE_W'(BIT_STI);
  localparam logic [CODE_W-1:0] CAUSE_MTI = CODE_W'(BIT_MTI);
  localparam logic [CODE_W-1:0] CAUSE_UEI = CODE_W'(BIT_UEI);
  localparam logic [CODE_W-1:0] CAUSE_SEI = CODE_W'(BIT_SEI);
  localparam logic [CODE_W-1:0] CAUSE_MEI = CODE_W'(BIT_MEI);

  localparam logic [IRQ_W-1:0] INTR_MASK = 12'hBBB;

  // Element N_SRC-1 is the highest priority source
  localparam logic [N_SRC-1:0][CODE_W-1:0] PRIO_ORDER = {
    CAUSE_MEI, CAUSE_MSI, CAUSE_MTI, CAUSE_SEI, CAUSE_SSI,
    CAUSE_STI, CAUSE_UEI, CAUSE_USI, CAUSE_UTI
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_TAKEN = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] code;
  } prio_t;

  function automatic logic [XLEN-1:0] mk_cause(input logic [CODE_W-1:0] code);
    logic [XLEN-1:0] c;
    c                = '0;
    c[XLEN-1]        = 1'b1;
    c[CODE_W-1:0]    = code;
    return c;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder over the qualified interrupt vector (combinational).
module intr_prio_enc
  import intr_pkg::*;
(
  input  logic [IRQ_W-1:0]  act,
  output logic              valid,
  output logic [CODE_W-1:0] code
);

  // Walk from lowest to highest priority so the highest pending source wins
  always_comb begin
    valid = 1'b0;
    code  = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (act[PRIO_ORDER[i]]) begin
        valid = 1'b1;
        code  = PRIO_ORDER[i];
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Machine interrupt controller: qualify, arbitrate, registered req/ack to the pipeline.
// Optional WFI stall support is built when INTR_WFI_EN is defined.
module intr_ctrl
  import intr_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mie,
  input  logic            mstatus_mie,
  input  logic            irq_ack,
  input  logic            mret,
  input  logic            wfi,
  output logic            irq_req,
  output logic [XLEN-1:0] irq_cause,
  output logic            irq_busy,
  output logic            wfi_stall
);

  logic [IRQ_W-1:0] act;
  prio_t            win;
  logic             cand;
  logic             src_qual;

  state_e           state_q, state_d;
  logic             irq_req_q, irq_req_d;
  logic [XLEN-1:0]  irq_cause_q, irq_cause_d;
  logic             irq_busy_q, irq_busy_d;

  assign act = mip[IRQ_W-1:0] & mie[IRQ_W-1:0] & INTR_MASK;

  intr_prio_enc u_prio (
    .act   (act),
    .valid (win.valid),
    .code  (win.code)
  );

  assign cand     = win.valid & mstatus_mie;
  // Latched source still pending, enabled and globally enabled
  assign src_qual = act[irq_cause_q[CODE_W-1:0]] & mstatus_mie;

  always_comb begin
    state_d     = state_q;
    irq_cause_d = irq_cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cand) begin
          state_d     = ST_REQ;
          irq_cause_d = mk_cause(win.code);
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d = ST_TAKEN;
        end else if (!src_qual) begin
          state_d = ST_IDLE;
        end
      end
      ST_TAKEN: begin
        if (mret) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_req_d  = (state_d == ST_REQ);
    irq_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      irq_req_q   <= 1'b0;
      irq_cause_q <= '0;
      irq_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_req_q   <= irq_req_d;
      irq_cause_q <= irq_cause_d;
      irq_busy_q  <= irq_busy_d;
    end
  end

  assign irq_req   = irq_req_q;
  assign irq_cause = irq_cause_q;
  assign irq_busy  = irq_busy_q;

`ifdef INTR_WFI_EN
  logic wfi_stall_q, wfi_stall_d;

  // Stall only arms from IDLE; any pending-and-enabled source wakes it
  always_comb begin
    wfi_stall_d = wfi_stall_q;
    if (state_q == ST_IDLE) begin
      if (wfi_stall_q) begin
        if (act != '0) begin
          wfi_stall_d = 1'b0;
        end
      end else if (wfi && (act == '0)) begin
        wfi_stall_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wfi_stall_q <= 1'b0;
    end else begin
      wfi_stall_q <= wfi_stall_d;
    end
  end

  assign wfi_stall = wfi_stall_q;
`else
  logic unused_wfi;
  assign unused_wfi = wfi;
  assign wfi_stall  = 1'b0;
`endif

  logic unused_hi;
  assign unused_hi = ^{mip[XLEN-1:IRQ_W], mie[XLEN-1:IRQ_W]};

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed scenarios then randomized traffic.
module tb_intr_ctrl;

  typedef struct packed {
    logic        req;
    logic [31:0] cause;
    logic        busy;
    logic        stall;
  } exp_t;

`ifdef INTR_WFI_EN
  localparam bit WFI_EN = 1'b1;
`else
  localparam bit WFI_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] mip;
  logic [31:0] mie;
  logic        mstatus_mie;
  logic        irq_ack;
  logic        mret;
  logic        wfi;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic        irq_busy;
  logic        wfi_stall;

  intr_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mip         (mip),
    .mie         (mie),
    .mstatus_mie (mstatus_mie),
    .irq_ack     (irq_ack),
    .mret        (mret),
    .wfi         (wfi),
    .irq_req     (irq_req),
    .irq_cause   (irq_cause),
    .irq_busy    (irq_busy),
    .wfi_stall   (wfi_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: 0 = no request, 1 = requesting, 2 = trap in flight
  int          m_mode  = 0;
  logic [31:0] m_cause = '0;
  logic        m_stall = 1'b0;
  int          prio_list [9] = '{11, 3, 7, 9, 1, 5, 8, 0, 4};

  logic        d_rst, d_msie, d_ack, d_mret, d_wfi;
  logic [31:0] d_mip, d_mie;

  task automatic model_step();
    logic [11:0] a12;
    int          nxt;
    int          src;
    int          winner;
    a12 = d_mip[11:0] & d_mie[11:0] & 12'hBBB;
    if (!d_rst) begin
      m_mode  = 0;
      m_cause = '0;
      m_stall = 1'b0;
    end else begin
      nxt = m_mode;
      if (m_mode == 0) begin
        if (WFI_EN) begin
          if (m_stall && a12 != 0) m_stall = 1'b0;
          else if (!m_stall && d_wfi && a12 == 0) m_stall = 1'b1;
        end
        if (d_msie && a12 != 0) begin
          winner = -1;
          for (int i = 0; i < 9; i++) begin
            if (winner < 0 && a12[prio_list[i]]) winner = prio_list[i];
          end
          nxt     = 1;
          m_cause = 32'h8000_0000 | 32'(winner);
        end
      end else if (m_mode == 1) begin
        src = int'(m_cause[3:0]);
        if (d_ack) nxt = 2;
        else if (!(a12[src] && d_msie)) nxt = 0;
      end else begin
        if (d_mret) nxt = 0;
      end
      m_mode = nxt;
    end
    exp_q.push_back('{req: (m_mode == 1), cause: m_cause, busy: (m_mode != 0), stall: m_stall});
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      rst_n       = d_rst;
      mip         = d_mip;
      mie         = d_mie;
      mstatus_mie = d_msie;
      irq_ack     = d_ack;
      mret        = d_mret;
      wfi         = d_wfi;
      model_step();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_ack();
    d_ack = 1'b1; tick(1); d_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    d_mret = 1'b1; tick(1); d_mret = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after each edge
  exp_t got;
  exp_t want;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got  = '{req: irq_req, cause: irq_cause, busy: irq_busy, stall: wfi_stall};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL cyc%0d outputs req/cause/busy/stall got %b/%h/%b/%b want %b/%h/%b/%b",
                   cycle, got.req, got.cause, got.busy, got.stall,
                   want.req, want.cause, want.busy, want.stall);
        end
      end
    end
  end

  initial begin
    d_rst = 1'b0; d_mip = '0; d_mie = '0; d_msie = 1'b0;
    d_ack = 1'b0; d_mret = 1'b0; d_wfi = 1'b0;
    tick(2);
    d_rst = 1'b1;
    tick(1);

    // Single MTI request, ack, hold busy until mret
    d_mie = 32'h888; d_msie = 1'b1; d_mip = 32'h080;
    tick(3); pulse_ack(); d_mip = '0; tick(3); pulse_mret(); tick(2);

    // Priority: MEI, then MSI, then MTI
    d_mip = 32'h88A; d_mie = 32'h88A;
    tick(2); pulse_ack(); d_mip = 32'h08A; pulse_mret();
    tick(2); pulse_ack(); d_mip = 32'h080; pulse_mret();
    tick(2); pulse_ack(); d_mip = '0; pulse_mret(); tick(2);

    // Withdrawal by clearing mie[7], then ack in the same cycle as the clear
    d_mie = 32'h080; d_mip = 32'h080;
    tick(2); d_mie = '0; tick(2);
    d_mie = 32'h080; tick(2);
    d_mie = '0; d_ack = 1'b1; tick(1); d_ack = 1'b0;
    tick(2); pulse_mret(); tick(1);

    // No re-arbitration while in REQ
    d_mie = 32'h880; d_mip = 32'h080;
    tick(2); d_mip = 32'h880; tick(3);
    pulse_ack(); d_mip = '0; pulse_mret(); tick(2);

    // Global disable, then reset mid-REQ
    d_msie = 1'b0; d_mip = 32'h800; d_mie = 32'h800;
    tick(3); d_msie = 1'b1; tick(2);
    d_rst = 1'b0; tick(1); d_rst = 1'b1; d_mip = '0; tick(2);

    // WFI wake without global enable, then wake with it
    d_mie = '0; d_wfi = 1'b1; tick(2); d_wfi = 1'b0; tick(2);
    d_msie = 1'b0; d_mip = 32'h080; d_mie = 32'h080; tick(2);
    d_msie = 1'b1; tick(1); pulse_ack(); d_mip = '0; pulse_mret(); tick(1);
    d_wfi = 1'b1; tick(2); d_wfi = 1'b0; d_mip = 32'h080; tick(2);
    pulse_ack(); d_mip = '0; pulse_mret(); tick(1);
    d_wfi = 1'b1; tick(2); d_rst = 1'b0; tick(1); d_rst = 1'b1; d_wfi = 1'b0; tick(1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      d_rst  = ($urandom_range(0, 99) > 1);
      d_mip  = $urandom & $urandom & $urandom;
      d_mie  = $urandom | $urandom;
      d_msie = ($urandom_range(0, 99) < 85);
      d_ack  = ($urandom_range(0, 99) < 25);
      d_mret = ($urandom_range(0, 99) < 20);
      d_wfi  = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 3) == 0) d_mip = '0;
      tick(1);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending expectations got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
